// File: rtl/slt_pkg.sv
// Shared encodings and helpers for the sequential set-on-compare unit.
package slt_pkg;

    typedef enum logic [2:0] {
        OP_SLT  = 3'b000,
        OP_SLTU = 3'b001,
        OP_SEQ  = 3'b010,
        OP_SNE  = 3'b011,
        OP_SGE  = 3'b100,
        OP_SGEU = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_signed(input logic [2:0] op);
        return (op == OP_SLT) || (op == OP_SGE);
    endfunction

    function automatic logic set_bit(input logic [2:0] op, input logic lt, input logic eq);
        logic r;
        r = 1'b0;
        case (op)
            OP_SLT, OP_SLTU: r = lt;
            OP_SEQ:          r = eq;
            OP_SNE:          r = ~eq;
            OP_SGE, OP_SGEU: r = ~lt;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/slice_compare.sv
// Unsigned less-than / equality of one SLICE-bit chunk.
module slice_compare #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    output logic             lt,
    output logic             eq
);

    assign lt = (x < y);
    assign eq = (x == y);

endmodule

// File: rtl/slt_seq_compare.sv
// Multi-cycle set-on-compare: MSB-first slice compare with early exit,
// valid/ready on input and output.
module slt_seq_compare
    import slt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             lt,
    output logic             eq,
    output logic             illegal
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t            state, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [2:0]        op_q;
    logic [IDXW-1:0]   idx;
    logic [SLICE-1:0]  sx, sy;
    logic              s_lt, s_eq;
    logic              accept, finish;

    assign sx = a_q[idx*SLICE +: SLICE];
    assign sy = b_q[idx*SLICE +: SLICE];

    slice_compare #(.SLICE(SLICE)) u_cmp (
        .x  (sx),
        .y  (sy),
        .lt (s_lt),
        .eq (s_eq)
    );

    assign in_ready = (state == S_IDLE) && !reset;

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state)
            S_IDLE: if (in_valid) begin
                accept  = 1'b1;
                state_d = S_CMP;
            end
            S_CMP: if (!s_eq || idx == '0) begin
                finish  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (reset) begin
            state_d = S_IDLE;
            accept  = 1'b0;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // Flipping the sign bit maps two's complement order onto unsigned order.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= is_signed(op) ? (a ^ MSB_MASK) : a;
            b_q  <= is_signed(op) ? (b ^ MSB_MASK) : b;
            op_q <= op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            illegal   <= 1'b0;
            idx       <= '0;
        end else begin
            if (accept) begin
                idx     <= IDX_TOP;
                illegal <= (op[2:1] == 2'b11);
            end
            if (state == S_CMP && !finish) idx <= idx - 1'b1;
            if (finish) begin
                lt        <= s_lt;
                eq        <= s_eq;
                result    <= WIDTH'(set_bit(op_q, s_lt, s_eq) & ~illegal);
                out_valid <= 1'b1;
            end
            if (state == S_DONE && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_slt_seq_compare.sv
// Directed self-checking bench for slt_seq_compare (WIDTH=32, SLICE=8).
module tb_slt_seq_compare;
    import slt_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        lt, eq, illegal;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    slt_seq_compare #(.WIDTH(32), .SLICE(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .lt        (lt),
        .eq        (eq),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one op, wait for out_valid, check latency and outputs, hold
    // out_ready low for 'hold' cycles checking stability, then retire.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb2,
                          input logic [2:0] top, input int hold, input int exp_lat,
                          input logic exp_res, input logic exp_lt, input logic exp_eq,
                          input logic exp_ill, input logic poke_in);
        int lat;
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tb2; op = top; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (poke_in) begin
            a = 32'hFFFF_FFFF; b = 32'h0; op = OP_SEQ; in_valid = 1'b1;
        end
        lat = 0;
        while (!out_valid && lat < 10) begin
            check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".result"}, result, {31'd0, exp_res});
        check({tag, ".lt"}, 32'(lt), 32'(exp_lt));
        check({tag, ".eq"}, 32'(eq), 32'(exp_eq));
        check({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_result"}, result, {31'd0, exp_res});
            check({tag, ".hold_lt"}, 32'(lt), 32'(exp_lt));
            check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        #1;
        check("reset.in_ready_low", 32'(in_ready), 32'd0);
        tick(); tick();
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result", result, 32'd0);
        check("reset.lt", 32'(lt), 32'd0);
        check("reset.eq", 32'(eq), 32'd0);
        check("reset.illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        #1;
        check("reset.in_ready_after", 32'(in_ready), 32'd1);

        // out_ready in IDLE must not produce anything
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        check("idle_out_ready.valid", 32'(out_valid), 32'd0);
        check("idle_out_ready.in_ready", 32'(in_ready), 32'd1);

        run_op("slt_m1_1",   32'hFFFF_FFFF, 32'h0000_0001, OP_SLT,  0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("sltu_m1_1",  32'hFFFF_FFFF, 32'h0000_0001, OP_SLTU, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("slt_ovf",    32'h7FFF_FFFF, 32'h8000_0000, OP_SLT,  0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sge_ovf",    32'h7FFF_FFFF, 32'h8000_0000, OP_SGE,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("seq_eq",     32'h1234_5678, 32'h1234_5678, OP_SEQ,  0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sne_eq",     32'h1234_5678, 32'h1234_5678, OP_SNE,  0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sltu_hold",  32'h0000_0010, 32'h0000_0011, OP_SLTU, 5, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("sgeu_lo",    32'h0000_0003, 32'h0000_0005, OP_SGEU, 0, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("sne_mid",    32'h00AB_0000, 32'h00AC_0000, OP_SNE,  0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Abort: reset during the 2nd CMP cycle of a SEQ on equal operands
        a = 32'hCAFE_F00D; b = 32'hCAFE_F00D; op = OP_SEQ; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("abort.in_ready_in_reset", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("abort.in_ready_after", 32'(in_ready), 32'd1);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort.no_valid", 32'(out_valid), 32'd0);
        end

        run_op("illegal_110", 32'h0000_0005, 32'h0000_0005, 3'b110, 0, 4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("legal_after", 32'h8000_0000, 32'h0000_0000, OP_SLT, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/slt_seq_compare.md
Name: slt_seq_compare

Overview:
- Multi-cycle, parametrised set-on-compare unit for the MIPS datapath; next generation of the single-cycle 32-bit set-less-than.
- Supports signed and unsigned less-than, equality and greater-or-equal variants, selected by an opcode.
- Compares MSB-first in SLICE-bit chunks, one chunk per cycle, and terminates early on the first differing chunk.
- Correct across the full signed range with no subtract-overflow error. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 8, bits compared per cycle; NSLICE = WIDTH/SLICE, and NSLICE >= 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  unit can accept
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  000 SLT, 001 SLTU, 010 SEQ, 011 SNE, 100 SGE, 101 SGEU, 11x illegal
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  zero-extended 0/1 set result
- lt  out  1  raw A<B under the selected signedness
- eq  out  1  raw A==B
- illegal  out  1  op was 11x for this result

Interface: one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:
- States are IDLE, CMP and DONE.
- Reset, sampled at the clk edge, takes priority over everything:
  - Next state is IDLE.
  - out_valid=0, result=0, lt=0, eq=0, illegal=0, slice index=0.
  - in_ready=0 in any cycle where reset is high.
- Reset asserted in CMP or DONE aborts the operation silently; the result is discarded and no out_valid is produced.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, op and illegal=(op[2:1]==11), set idx=NSLICE-1, and go to CMP.
  - For signed ops (SLT, SGE), invert bit WIDTH-1 of both latched operands, so that the subsequent unsigned compare is a correct signed compare.
- CMP:
  - in_ready=0. Compare slice idx, bits [idx*SLICE +: SLICE], as unsigned.
  - Slices differ: lt=(a_slice<b_slice), eq=0, go to DONE.
  - Slices equal and idx==0: lt=0, eq=1, go to DONE.
  - Otherwise: idx=idx-1 and stay in CMP.
- DONE:
  - out_valid=1 and in_ready=0.
  - result bit0 by op: SLT/SLTU=lt; SEQ=eq; SNE=~eq; SGE/SGEU=~lt; illegal=0. Bits [WIDTH-1:1]=0 always.
  - result, lt, eq and illegal stay stable while out_valid&&!out_ready.
  - On out_ready, go to IDLE and drop out_valid.
- Latency:
  - out_valid rises k cycles after the accept edge, where k is the number of slices examined (1..NSLICE).
  - Worst case for 32/8 is 4 cycles.
  - Throughput is one op per k+2 cycles minimum; there is no overlap between consecutive ops.
- Boundary conditions:
  - in_valid held high in CMP or DONE is ignored and not latched.
  - out_ready high outside DONE has no effect.
  - NSLICE==1 gives a fixed 1-cycle compare.
- Outputs are registered, except in_ready, which is decoded from state and reset.

Decomposition:
- Shared package slt_pkg:
  - op encodings OP_SLT, OP_SLTU, OP_SEQ, OP_SNE, OP_SGE, OP_SGEU.
  - state encodings S_IDLE, S_CMP, S_DONE.
  - an is_signed(op) helper.
- Sub-module slice_compare: combinational, parameter SLICE; inputs x, y; outputs lt, eq (unsigned). Instantiated once and fed by a slice mux on idx.

Test Plan:
- WIDTH=32, SLICE=8, op SLT, a=0xFFFFFFFF (-1), b=0x00000001 -> result=1, lt=1; out_valid 1 cycle after accept (MSB slice differs).
- op SLTU, same operands -> result=0, lt=0, latency 1.
- op SLT, a=0x7FFFFFFF, b=0x80000000 (overflow case for subtract) -> result=0; op SGE -> result=1.
- op SEQ, a=b=0x12345678 -> result=1, eq=1, out_valid exactly 4 cycles after accept; SNE on the same operands -> 0.
- op SLTU, a=0x00000010, b=0x00000011, out_ready held 0 for 5 cycles -> result=1, held stable, in_ready=0 throughout; IDLE one cycle after out_ready=1.
- Reset pulsed in the 2nd CMP cycle of a SEQ on equal operands -> no out_valid; in_ready=1 the cycle after reset drops; then op=110 -> illegal=1, result=0.
